// File: rtl/alu_mc_if.sv
// Bundles the request operands and result outputs of the multi-cycle ALU.
// The master side drives Start/operands/opcode; the slave side returns status and results.
// Pure wiring: no storage, no latency, no flow control of its own.
interface alu_mc_if #(
   parameter int WIDTH = 32
) ();
   logic             Start;
   logic [WIDTH-1:0] SrcA;
   logic [WIDTH-1:0] SrcB;
   logic [2:0]       ALUControl;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] ALUResult;
   logic [WIDTH-1:0] ALUResultHi;
   logic             Zero;
   logic             DivByZero;

   modport master (
      output Start, SrcA, SrcB, ALUControl,
      input  Busy, Done, ALUResult, ALUResultHi, Zero, DivByZero
   );

   modport slave (
      input  Start, SrcA, SrcB, ALUControl,
      output Busy, Done, ALUResult, ALUResultHi, Zero, DivByZero
   );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: logic/add/sub/slt in one cycle, unsigned shift-add multiply and restoring divide.
// Latency: 1 cycle for single-cycle ops and divide-by-zero, WIDTH+1 cycles for MULU/DIVU.
// Backpressure: Start is only sampled in IDLE (Busy low); requests while Busy are dropped, not queued.
module alu_mc #(
   parameter int WIDTH = 32
) (
   input logic    CLK,
   input logic    RST,
   alu_mc_if.slave bus
);
   localparam int             CW      = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LP_LAST = CW'(WIDTH);

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_DIVU = 3'b011;
   localparam logic [2:0] OP_SUB  = 3'b100;
   localparam logic [2:0] OP_MULU = 3'b101;
   localparam logic [2:0] OP_SLT  = 3'b110;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_opnd;     // multiplicand or divisor, held for the whole iteration
   logic [WIDTH-1:0] r_hi;       // partial product high half / partial remainder
   logic [WIDTH-1:0] r_lo;       // multiplier shifting out / dividend shifting into quotient
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_res_hi;
   logic             r_zero;
   logic             r_dbz;

   logic             w_is_mul;
   logic             w_is_div;
   logic             w_div0;
   logic [WIDTH-1:0] w_alu;
   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH-1:0] w_mul_hi;
   logic [WIDTH-1:0] w_mul_lo;
   logic [WIDTH:0]   w_div_sh;
   logic [WIDTH:0]   w_div_diff;
   logic             w_div_ge;
   logic [WIDTH-1:0] w_div_hi;
   logic [WIDTH-1:0] w_div_lo;
   logic [CW-1:0]    w_cnt_nxt;
   logic             w_last;

   assign w_is_mul = (bus.ALUControl == OP_MULU);
   assign w_is_div = (bus.ALUControl == OP_DIVU);
   assign w_div0   = w_is_div && (bus.SrcB == '0);

   // Single-cycle result straight from the live operands, used only at acceptance
   always_comb begin
      w_alu = '0;
      case (bus.ALUControl)
         OP_AND:  w_alu = bus.SrcA & bus.SrcB;
         OP_OR:   w_alu = bus.SrcA | bus.SrcB;
         OP_ADD:  w_alu = bus.SrcA + bus.SrcB;
         OP_SUB:  w_alu = bus.SrcA - bus.SrcB;
         OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, (bus.SrcA < bus.SrcB)};
         default: w_alu = '0;
      endcase
   end

   // One shift-add step: add multiplicand if the multiplier LSB is set, then shift {hi,lo} right
   assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
   assign w_mul_hi  = w_mul_sum[WIDTH:1];
   assign w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

   // One restoring step: shift in next dividend bit, keep the difference if it did not borrow
   assign w_div_sh   = {r_hi, r_lo[WIDTH-1]};
   assign w_div_diff = w_div_sh - {1'b0, r_opnd};
   assign w_div_ge   = ~w_div_diff[WIDTH];
   assign w_div_hi   = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
   assign w_div_lo   = {r_lo[WIDTH-2:0], w_div_ge};

   // Counter stops at WIDTH on the final step, so it never wraps
   assign w_cnt_nxt = r_cnt + 1'b1;
   assign w_last    = (w_cnt_nxt == LP_LAST);

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state selection
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.Start) begin
               if (w_is_mul)                 w_state_nxt = S_MUL;
               else if (w_is_div && !w_div0) w_state_nxt = S_DIV;
               else                          w_state_nxt = S_DONE;
            end
         end
         S_MUL:   if (w_last) w_state_nxt = S_DONE;
         S_DIV:   if (w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Operand capture, iteration datapath and result registers (results change only entering DONE)
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_cnt    <= '0;
         r_opnd   <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_res    <= '0;
         r_res_hi <= '0;
         r_zero   <= 1'b1;
         r_dbz    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.Start) begin
                  r_cnt <= '0;
                  if (w_is_mul) begin
                     r_opnd <= bus.SrcA;
                     r_lo   <= bus.SrcB;
                     r_hi   <= '0;
                  end else if (w_is_div && !w_div0) begin
                     r_opnd <= bus.SrcB;
                     r_lo   <= bus.SrcA;
                     r_hi   <= '0;
                  end else if (w_div0) begin
                     r_res    <= '1;
                     r_res_hi <= bus.SrcA;
                     r_zero   <= 1'b0;
                     r_dbz    <= 1'b1;
                  end else begin
                     r_res    <= w_alu;
                     r_res_hi <= '0;
                     r_zero   <= (w_alu == '0);
                     r_dbz    <= 1'b0;
                  end
               end
            end
            S_MUL: begin
               r_cnt <= w_cnt_nxt;
               r_hi  <= w_mul_hi;
               r_lo  <= w_mul_lo;
               if (w_last) begin
                  r_res    <= w_mul_lo;
                  r_res_hi <= w_mul_hi;
                  r_zero   <= (w_mul_lo == '0);
                  r_dbz    <= 1'b0;
               end
            end
            S_DIV: begin
               r_cnt <= w_cnt_nxt;
               r_hi  <= w_div_hi;
               r_lo  <= w_div_lo;
               if (w_last) begin
                  r_res    <= w_div_lo;
                  r_res_hi <= w_div_hi;
                  r_zero   <= (w_div_lo == '0);
                  r_dbz    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.Busy        = (r_state != S_IDLE);
   assign bus.Done        = (r_state == S_DONE);
   assign bus.ALUResult   = r_res;
   assign bus.ALUResultHi = r_res_hi;
   assign bus.Zero        = r_zero;
   assign bus.DivByZero   = r_dbz;
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: a 32-bit and an 8-bit instance checked every cycle against an arithmetic model,
// plus literal expected results/latencies for each completed operation and literal reset values.
module tb_alu_mc;
   localparam logic [2:0] OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b010, OP_DIVU = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100, OP_MULU = 3'b101, OP_SLT = 3'b110, OP_ZERO = 3'b111;

   typedef struct packed {
      int          rem;   // cycles left until back in IDLE (0 = idle, 1 = done cycle)
      int          acc;   // edge number of the last acceptance
      logic [63:0] res;
      logic [63:0] hi;
      logic [63:0] pres;
      logic [63:0] phi;
      logic        zero;
      logic        dbz;
      logic        pdbz;
   } mst_t;

   typedef struct packed {
      logic [63:0] res;
      logic [63:0] hi;
      logic        dbz;
      logic        zero;
      int          lat;
   } lit_t;

   logic CLK = 1'b0;
   logic RST;
   logic tb_end;
   int   m_edge = 0;
   mst_t m [2];
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_done [2];
   int   cyc = 0;

   always #5 CLK = ~CLK;

   alu_mc_if #(.WIDTH(32)) b32 ();
   alu_mc_if #(.WIDTH(8))  b8  ();

   alu_mc #(.WIDTH(32)) u_dut32 (.CLK(CLK), .RST(RST), .bus(b32));
   alu_mc #(.WIDTH(8))  u_dut8  (.CLK(CLK), .RST(RST), .bus(b8));

   // Reference arithmetic for one operation of width w
   function automatic void ref_op(input int w, input logic [2:0] op, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] r, output logic [63:0] h,
                                  output logic dz, output int lat);
      logic [63:0] mask;
      logic [63:0] p;
      mask = (64'd1 << w) - 64'd1;
      r = '0; h = '0; dz = 1'b0; lat = 1;
      case (op)
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_ADD: r = (a + b) & mask;
         OP_SUB: r = (a - b) & mask;
         OP_SLT: r = (a < b) ? 64'd1 : 64'd0;
         OP_MULU: begin
            p = a * b; r = p & mask; h = p >> w; lat = w + 1;
         end
         OP_DIVU: begin
            if (b == 0) begin r = mask; h = a; dz = 1'b1; end
            else begin r = a / b; h = a % b; lat = w + 1; end
         end
         default: r = '0;
      endcase
   endfunction

   function automatic mst_t rst_st();
      mst_t n;
      n = '0;
      n.zero = 1'b1;
      return n;
   endfunction

   function automatic mst_t step(mst_t c, logic st, logic [2:0] op, logic [63:0] a, logic [63:0] b,
                                 int w, int e);
      mst_t        n;
      logic [63:0] r, h;
      logic        dz;
      int          lat;
      n = c;
      if (n.rem > 0) n.rem = n.rem - 1;
      else if (st) begin
         ref_op(w, op, a, b, r, h, dz, lat);
         n.pres = r; n.phi = h; n.pdbz = dz; n.rem = lat; n.acc = e;
      end
      if (n.rem == 1) begin
         n.res = n.pres; n.hi = n.phi; n.dbz = n.pdbz; n.zero = (n.pres == 0);
      end
      return n;
   endfunction

   // Transaction-level model of both instances
   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         m[0] <= rst_st();
         m[1] <= rst_st();
      end else begin
         m_edge <= m_edge + 1;
         m[0] <= step(m[0], b32.Start, b32.ALUControl, 64'(b32.SrcA), 64'(b32.SrcB), 32, m_edge + 1);
         m[1] <= step(m[1], b8.Start, b8.ALUControl, 64'(b8.SrcA), 64'(b8.SrcB), 8, m_edge + 1);
      end
   end

   function automatic logic [63:0] get_res(int s);
      return (s == 0) ? 64'(b32.ALUResult) : 64'(b8.ALUResult);
   endfunction
   function automatic logic [63:0] get_hi(int s);
      return (s == 0) ? 64'(b32.ALUResultHi) : 64'(b8.ALUResultHi);
   endfunction
   function automatic logic get_busy(int s);
      return (s == 0) ? b32.Busy : b8.Busy;
   endfunction
   function automatic logic get_done(int s);
      return (s == 0) ? b32.Done : b8.Done;
   endfunction
   function automatic logic get_zero(int s);
      return (s == 0) ? b32.Zero : b8.Zero;
   endfunction
   function automatic logic get_dbz(int s);
      return (s == 0) ? b32.DivByZero : b8.DivByZero;
   endfunction

   function automatic lit_t mk(logic [63:0] r, logic [63:0] h, logic dz, logic z, int lat);
      lit_t e;
      e.res = r; e.hi = h; e.dbz = dz; e.zero = z; e.lat = lat;
      return e;
   endfunction

   // Hand-computed results of each completed operation, in issue order
   function automatic lit_t lit(int s, int k);
      lit_t e;
      e = '0;
      if (s == 0) begin
         case (k)
            0:  e = mk(64'h0,        64'h0,        1'b0, 1'b1, 1);   // ADD FFFFFFFF+1
            1:  e = mk(64'h1,        64'hFFFFFFFE, 1'b0, 1'b0, 33);  // MULU FFFFFFFF^2
            2:  e = mk(64'd14,       64'd2,        1'b0, 1'b0, 33);  // DIVU 100/7
            3:  e = mk(64'hFFFFFFFF, 64'd5,        1'b1, 1'b0, 1);   // DIVU 5/0
            4:  e = mk(64'h00F0,     64'h0,        1'b0, 1'b0, 1);   // AND
            5:  e = mk(64'hFFFFFFFE, 64'h0,        1'b0, 1'b0, 1);   // SUB 3-5
            6:  e = mk(64'h0,        64'h0,        1'b0, 1'b1, 1);   // SLT 5<3
            7:  e = mk(64'h1234,     64'h0,        1'b0, 1'b0, 1);   // OR
            8:  e = mk(64'h0,        64'h0,        1'b0, 1'b1, 1);   // opcode 111
            9:  e = mk(64'd12,       64'h0,        1'b0, 1'b0, 33);  // MULU 3*4, inputs changing
            10: e = mk(64'd11,       64'h0,        1'b0, 1'b0, 1);   // ADD 5+6 held Start
            11: e = mk(64'd1,        64'h0,        1'b0, 1'b0, 1);   // SLT 2<3 after reset
            default: e = '0;
         endcase
      end else begin
         case (k)
            0: e = mk(64'h01, 64'hFE, 1'b0, 1'b0, 9);   // MULU FF*FF
            1: e = mk(64'd22, 64'd2,  1'b0, 1'b0, 9);   // DIVU 200/9
            2: e = mk(64'h10, 64'h0,  1'b0, 1'b0, 1);   // ADD F0+20
            default: e = '0;
         endcase
      end
      return e;
   endfunction

   task automatic chk(string nm, int s, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[w%0d] cyc %0d: got 0x%0h expected 0x%0h", nm, (s == 0) ? 32 : 8, cyc, act, exp);
      end
   endtask

   // Compare process: every cycle against the model, literals at reset and at each Done
   initial begin : cmp
      n_done[0] = 0;
      n_done[1] = 0;
      forever begin
         @(negedge CLK);
         cyc++;
         if (cyc > 5000) begin
            n_chk++;
            n_fail++;
            $display("FAIL watchdog: got %0d cycles, expected at most 5000", cyc);
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
         end
         for (int s = 0; s < 2; s++) begin
            chk("busy", s, 64'(get_busy(s)), 64'(m[s].rem > 0));
            chk("done", s, 64'(get_done(s)), 64'(m[s].rem == 1));
            chk("res",  s, get_res(s), m[s].res);
            chk("hi",   s, get_hi(s),  m[s].hi);
            chk("zero", s, 64'(get_zero(s)), 64'(m[s].zero));
            chk("dbz",  s, 64'(get_dbz(s)),  64'(m[s].dbz));
            if (RST) begin
               chk("rst_busy", s, 64'(get_busy(s)), 64'd0);
               chk("rst_done", s, 64'(get_done(s)), 64'd0);
               chk("rst_res",  s, get_res(s), 64'd0);
               chk("rst_hi",   s, get_hi(s),  64'd0);
               chk("rst_zero", s, 64'(get_zero(s)), 64'd1);
               chk("rst_dbz",  s, 64'(get_dbz(s)),  64'd0);
            end else if (get_done(s)) begin
               if (n_done[s] < ((s == 0) ? 12 : 3)) begin
                  lit_t e;
                  e = lit(s, n_done[s]);
                  chk("lit_res",  s, get_res(s), e.res);
                  chk("lit_hi",   s, get_hi(s),  e.hi);
                  chk("lit_dbz",  s, 64'(get_dbz(s)),  64'(e.dbz));
                  chk("lit_zero", s, 64'(get_zero(s)), 64'(e.zero));
                  chk("lit_lat",  s, 64'(m_edge + 1 - m[s].acc), 64'(e.lat));
               end else begin
                  chk("extra_done", s, 64'(get_done(s)), 64'd0);
               end
               n_done[s]++;
            end
         end
         if (tb_end) begin
            chk("n_done", 0, 64'(n_done[0]), 64'd12);
            chk("n_done", 1, 64'(n_done[1]), 64'd3);
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
         end
      end
   end

   task automatic drv(int s, logic st, logic [2:0] op, logic [63:0] a, logic [63:0] b);
      if (s == 0) begin
         b32.Start = st; b32.ALUControl = op; b32.SrcA = a[31:0]; b32.SrcB = b[31:0];
      end else begin
         b8.Start = st; b8.ALUControl = op; b8.SrcA = a[7:0]; b8.SrcB = b[7:0];
      end
   endtask

   task automatic wait_idle(int s);
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (!get_busy(s)) break;
      end
   endtask

   task automatic wait_done(int s);
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (get_done(s)) break;
      end
   endtask

   task automatic issue(int s, logic [2:0] op, logic [63:0] a, logic [63:0] b);
      @(negedge CLK);
      drv(s, 1'b1, op, a, b);
      @(negedge CLK);
      drv(s, 1'b0, OP_AND, 64'h0, 64'h0);
      wait_idle(s);
   endtask

   initial begin : stim
      RST    = 1'b1;
      tb_end = 1'b0;
      drv(0, 1'b0, OP_AND, 64'h0, 64'h0);
      drv(1, 1'b0, OP_AND, 64'h0, 64'h0);
      repeat (3) @(negedge CLK);
      #2 RST = 1'b0;

      issue(0, OP_ADD,  64'hFFFFFFFF, 64'h1);
      issue(0, OP_MULU, 64'hFFFFFFFF, 64'hFFFFFFFF);
      issue(0, OP_DIVU, 64'd100, 64'd7);
      issue(0, OP_DIVU, 64'd5, 64'd0);
      issue(0, OP_AND,  64'hF0F0, 64'h0FF0);
      issue(0, OP_SUB,  64'd3, 64'd5);
      issue(0, OP_SLT,  64'd5, 64'd3);
      issue(0, OP_OR,   64'h1200, 64'h0034);
      issue(0, OP_ZERO, 64'hABCD, 64'h1234);
      issue(1, OP_MULU, 64'hFF, 64'hFF);
      issue(1, OP_DIVU, 64'd200, 64'd9);
      issue(1, OP_ADD,  64'hF0, 64'h20);

      // Start held high with new operands while busy; next acceptance only after DONE
      @(negedge CLK);
      drv(0, 1'b1, OP_MULU, 64'd3, 64'd4);
      @(negedge CLK);
      drv(0, 1'b1, OP_ADD, 64'd5, 64'd6);
      wait_done(0);
      @(negedge CLK);
      @(negedge CLK);
      drv(0, 1'b0, OP_AND, 64'h0, 64'h0);
      wait_idle(0);

      // Reset mid-multiply aborts without a Done pulse
      @(negedge CLK);
      drv(0, 1'b1, OP_MULU, 64'd7, 64'd9);
      @(negedge CLK);
      drv(0, 1'b0, OP_AND, 64'h0, 64'h0);
      repeat (9) @(negedge CLK);
      #2 RST = 1'b1;
      @(negedge CLK);
      #2 RST = 1'b0;
      repeat (3) @(negedge CLK);
      issue(0, OP_SLT, 64'd2, 64'd3);

      @(negedge CLK);
      #2 tb_end = 1'b1;
   end
endmodule
